tri_assembler: RTL and testbench

Frame-level sequencer between vertex memory, the MVP transform unit and the rasterizer. On `frame_start` it latches camera pose and has the transform unit rebuild its MVP matrix. It then walks vertex memory, pushing each vertex through the transform and collecting screen coordinates. Each group of three results is emitted as one triangle on a valid/ready interface to the rasterizer.

---
 rtl/gfx_pkg.sv | 34 +++
 rtl/tri_backface_cull.sv | 39 +++
 rtl/tri_assembler.sv | 167 ++++++++++++++++
 tb/tb_tri_assembler.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// gfx_pkg: types and constants shared by the triangle assembly path.
//   state_t   - tri_assembler sequencer states
//   vertex_t  - packed {x,y,z} of 32-bit words (x in the top word)
//   FLOAT_ONE - IEEE-754 single 1.0
//   SCREEN_CX / SCREEN_CY - screen centre in pixels
package gfx_pkg;

  localparam logic [31:0] FLOAT_ONE = 32'h3f800000;
  localparam int          SCREEN_CX = 320;
  localparam int          SCREEN_CY = 240;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
  } vertex_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_MVP_ISSUE,
    ST_MVP_ARM,
    ST_MVP_WAIT,
    ST_CHECK,
    ST_FETCH,
    ST_LATCH,
    ST_XF_ISSUE,
    ST_XF_ARM,
    ST_XF_WAIT,
    ST_CULL,
    ST_EMIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/tri_backface_cull.sv
// tri_backface_cull: signed winding test on integer screen coordinates.
// Optional feature of tri_assembler, present only when TRI_BACKFACE_CULL_EN
// is defined.
//   clock, reset      - system clock, synchronous active-high reset
//   load              - capture the cross product of the presented vertices
//   x0,y0,x1,y1,x2,y2 - 32-bit signed integer screen coordinates
//   keep              - registered cross product is strictly positive
module tri_backface_cull (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] x0,
  input  logic [31:0] y0,
  input  logic [31:0] x1,
  input  logic [31:0] y1,
  input  logic [31:0] x2,
  input  logic [31:0] y2,
  output logic        keep
);

  logic signed [63:0] dx1, dy1, dx2, dy2, cross_d, cross_q;

  always_comb begin
    dx1     = $signed({{32{x1[31]}}, x1}) - $signed({{32{x0[31]}}, x0});
    dy1     = $signed({{32{y1[31]}}, y1}) - $signed({{32{y0[31]}}, y0});
    dx2     = $signed({{32{x2[31]}}, x2}) - $signed({{32{x0[31]}}, x0});
    dy2     = $signed({{32{y2[31]}}, y2}) - $signed({{32{y0[31]}}, y0});
    cross_d = dx1 * dy2 - dx2 * dy1;
  end

  always_ff @(posedge clock) begin
    if (reset) cross_q <= '0;
    else if (load) cross_q <= cross_d;
  end

  // Zero-area triangles count as back-facing.
  assign keep = (cross_q > 64'sd0);

endmodule

// File: rtl/tri_assembler.sv
// tri_assembler: frame sequencer between vertex memory, the MVP transform
// unit and the rasterizer. Optional back-face culling under the macro
// TRI_BACKFACE_CULL_EN (default build: every triangle is emitted).
//   clock, reset            - system clock, synchronous active-high reset
//   frame_start, num_verts  - frame request and vertex count
//   cam_*                   - camera pose, latched on accepted frame_start
//   vmem_addr / vmem_data   - vertex memory, one-cycle read latency
//   xf_*                    - transform unit command/result
//   tri_valid/ready, tri_*  - triangle output handshake
//   busy, frame_done        - frame status
//
// state       | meaning
// IDLE        | waiting for frame_start
// MVP_ISSUE   | start pulse for matrix rebuild
// MVP_ARM     | skip stale xf_done
// MVP_WAIT    | wait for matrix rebuild
// CHECK       | enough vertices left for a full triangle?
// FETCH       | present vertex address
// LATCH       | register vertex into xf_x/y/z
// XF_ISSUE    | start pulse for vertex transform
// XF_ARM      | skip stale xf_done
// XF_WAIT     | wait for transform, capture result into slot
// CULL        | winding decision
// EMIT        | triangle offered to rasterizer
// DONE        | frame_done pulse
module tri_assembler
  import gfx_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    frame_start,
  input  logic [ADDR_W-1:0]       num_verts,
  input  logic [31:0]             cam_roll,
  input  logic [31:0]             cam_pitch,
  input  logic [31:0]             cam_yaw,
  input  logic [31:0]             cam_x,
  input  logic [31:0]             cam_y,
  input  logic [31:0]             cam_z,
  output logic [ADDR_W-1:0]       vmem_addr,
  input  logic [95:0]             vmem_data,
  output logic                    xf_start,
  output logic                    xf_update_mvp,
  output logic [31:0]             xf_roll,
  output logic [31:0]             xf_pitch,
  output logic [31:0]             xf_yaw,
  output logic [31:0]             xf_x,
  output logic [31:0]             xf_y,
  output logic [31:0]             xf_z,
  input  logic                    xf_done,
  input  logic [31:0]             xf_ox,
  input  logic [31:0]             xf_oy,
  input  logic [31:0]             xf_oz,
  output logic                    tri_valid,
  input  logic                    tri_ready,
  output logic [2:0][31:0]        tri_x,
  output logic [2:0][31:0]        tri_y,
  output logic [2:0][31:0]        tri_z,
  output logic                    busy,
  output logic                    frame_done
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] vidx, nverts;
  logic [1:0]        slot;
  vertex_t           xf_in;
  logic              cull_keep;
  logic              last_capture;
  logic [ADDR_W:0]   vidx_p3;

  // One extra bit so vidx+3 cannot wrap near the top of the address space.
  assign vidx_p3      = {1'b0, vidx} + (ADDR_W+1)'(3);
  assign last_capture = (state == ST_XF_WAIT) && xf_done && (slot == 2'd2);

`ifdef TRI_BACKFACE_CULL_EN
  // Vertex 2 is taken straight from the transform so the keep flag is
  // registered by the time CULL is entered.
  tri_backface_cull u_cull (
    .clock (clock),
    .reset (reset),
    .load  (last_capture),
    .x0    (tri_x[0]),
    .y0    (tri_y[0]),
    .x1    (tri_x[1]),
    .y1    (tri_y[1]),
    .x2    (xf_ox),
    .y2    (xf_oy),
    .keep  (cull_keep)
  );
`else
  assign cull_keep = 1'b1;
`endif

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:      if (frame_start) state_n = ST_MVP_ISSUE;
      ST_MVP_ISSUE: state_n = ST_MVP_ARM;
      ST_MVP_ARM:   state_n = ST_MVP_WAIT;
      ST_MVP_WAIT:  if (xf_done) state_n = ST_CHECK;
      ST_CHECK:     state_n = (vidx_p3 > {1'b0, nverts}) ? ST_DONE : ST_FETCH;
      ST_FETCH:     state_n = ST_LATCH;
      ST_LATCH:     state_n = ST_XF_ISSUE;
      ST_XF_ISSUE:  state_n = ST_XF_ARM;
      ST_XF_ARM:    state_n = ST_XF_WAIT;
      ST_XF_WAIT:   if (xf_done) state_n = (slot == 2'd2) ? ST_CULL : ST_FETCH;
      ST_CULL:      state_n = cull_keep ? ST_EMIT : ST_CHECK;
      ST_EMIT:      if (tri_ready) state_n = ST_CHECK;
      ST_DONE:      state_n = ST_IDLE;
      default:      state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      vidx          <= '0;
      slot          <= '0;
      nverts        <= '0;
      xf_in         <= '0;
      xf_update_mvp <= 1'b0;
      xf_roll       <= '0;
      xf_pitch      <= '0;
      xf_yaw        <= '0;
      tri_x         <= '0;
      tri_y         <= '0;
      tri_z         <= '0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: if (frame_start) begin
          nverts        <= num_verts;
          vidx          <= '0;
          slot          <= '0;
          xf_roll       <= cam_roll;
          xf_pitch      <= cam_pitch;
          xf_yaw        <= cam_yaw;
          xf_in         <= '{x: cam_x, y: cam_y, z: cam_z};
          xf_update_mvp <= 1'b1;
        end
        ST_LATCH: begin
          xf_in         <= vmem_data;
          xf_update_mvp <= 1'b0;
        end
        ST_XF_WAIT: if (xf_done) begin
          tri_x[slot] <= xf_ox;
          tri_y[slot] <= xf_oy;
          tri_z[slot] <= xf_oz;
          vidx        <= vidx + 1'b1;
          slot        <= (slot == 2'd2) ? 2'd0 : slot + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign xf_x       = xf_in.x;
  assign xf_y       = xf_in.y;
  assign xf_z       = xf_in.z;
  assign vmem_addr  = (state == ST_FETCH) ? vidx : '0;
  assign xf_start   = (state == ST_MVP_ISSUE) || (state == ST_XF_ISSUE);
  assign tri_valid  = (state == ST_EMIT);
  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_DONE);

endmodule

// File: tb/tb_tri_assembler.sv
// tb_tri_assembler: directed bench for tri_assembler with a vertex memory
// model and a fixed-latency transform model.
module tb_tri_assembler;
  import gfx_pkg::*;

  localparam int ADDR_W = 10;
  localparam logic [31:0] F0  = 32'h00000000;
  localparam logic [31:0] F1  = 32'h3f800000;
  localparam logic [31:0] F5  = 32'h40a00000;
  localparam logic [31:0] F10 = 32'h41200000;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              frame_start = 1'b0;
  logic [ADDR_W-1:0] num_verts = '0;
  logic [31:0]       cam_roll = 32'h3f000000, cam_pitch = 32'h3e800000, cam_yaw = 32'h40490fdb;
  logic [31:0]       cam_x = 32'h40400000, cam_y = 32'h40800000, cam_z = 32'h40a00000;
  logic [ADDR_W-1:0] vmem_addr;
  logic [95:0]       vmem_data = '0;
  logic              xf_start, xf_update_mvp;
  logic [31:0]       xf_roll, xf_pitch, xf_yaw, xf_x, xf_y, xf_z;
  logic              xf_done = 1'b1;
  logic [31:0]       xf_ox = '0, xf_oy = '0, xf_oz = '0;
  logic              tri_valid;
  logic              tri_ready = 1'b0;
  logic [2:0][31:0]  tri_x, tri_y, tri_z;
  logic              busy, frame_done;

  tri_assembler #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start), .num_verts(num_verts),
    .cam_roll(cam_roll), .cam_pitch(cam_pitch), .cam_yaw(cam_yaw),
    .cam_x(cam_x), .cam_y(cam_y), .cam_z(cam_z),
    .vmem_addr(vmem_addr), .vmem_data(vmem_data),
    .xf_start(xf_start), .xf_update_mvp(xf_update_mvp),
    .xf_roll(xf_roll), .xf_pitch(xf_pitch), .xf_yaw(xf_yaw),
    .xf_x(xf_x), .xf_y(xf_y), .xf_z(xf_z),
    .xf_done(xf_done), .xf_ox(xf_ox), .xf_oy(xf_oy), .xf_oz(xf_oz),
    .tri_valid(tri_valid), .tri_ready(tri_ready),
    .tri_x(tri_x), .tri_y(tri_y), .tri_z(tri_z),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Float to integer for the small whole-number vertices used here.
  function automatic logic [31:0] f2i(input logic [31:0] f);
    int e;
    logic [31:0] m;
    int v;
    e = int'(f[30:23]);
    if (e < 127) return 32'd0;
    m = {8'h01, f[22:0]};
    if (e >= 150) v = int'(m << (e - 150));
    else          v = int'(m >> (150 - e));
    return f[31] ? -v : v;
  endfunction

  // Vertex memory: registered read.
  logic [95:0] mem [8];
  always @(posedge clock) vmem_data <= mem[vmem_addr[2:0]];

  // Transform model: xf_done low for 12 cycles after a start.
  int          xf_cnt = 0;
  logic [95:0] xf_arg = '0;
  always @(posedge clock) begin
    if (reset) begin
      xf_done <= 1'b1;
      xf_cnt  <= 0;
    end else if (xf_start) begin
      xf_done <= 1'b0;
      xf_cnt  <= 12;
      xf_arg  <= {xf_x, xf_y, xf_z};
    end else if (xf_cnt > 1) begin
      xf_cnt <= xf_cnt - 1;
    end else if (xf_cnt == 1) begin
      xf_cnt  <= 0;
      xf_done <= 1'b1;
      xf_ox   <= f2i(xf_arg[95:64]) + 32'd320;
      xf_oy   <= f2i(xf_arg[63:32]) + 32'd240;
      xf_oz   <= f2i(xf_arg[31:0]);
    end
  end

  // Monitors (never cleared; the sequence works on differences).
  int n_mvp = 0, n_vtx = 0, n_hi_addr = 0, n_tri = 0, n_unstable = 0, n_start_in_emit = 0;
  logic [2:0][31:0] rec_x [8], rec_y [8], rec_z [8];
  logic             p_valid = 1'b0, p_ready = 1'b0;
  logic [2:0][31:0] p_x = '0, p_y = '0, p_z = '0;
  always @(posedge clock) begin
    if (xf_start) begin
      if (xf_update_mvp) n_mvp++; else n_vtx++;
      if (tri_valid) n_start_in_emit++;
    end
    if (vmem_addr >= 10'd6) n_hi_addr++;
    if (p_valid && !p_ready && !reset &&
        (!tri_valid || tri_x != p_x || tri_y != p_y || tri_z != p_z)) n_unstable++;
    if (tri_valid && tri_ready) begin
      rec_x[n_tri % 8] = tri_x;
      rec_y[n_tri % 8] = tri_y;
      rec_z[n_tri % 8] = tri_z;
      n_tri++;
    end
    p_valid = tri_valid; p_ready = tri_ready;
    p_x = tri_x; p_y = tri_y; p_z = tri_z;
  end

  task automatic start_frame(input logic [ADDR_W-1:0] n);
    @(negedge clock);
    num_verts   = n;
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clock);
      if (frame_done) seen = 1;
    end
    chk({tag, "_frame_done"}, 64'(seen), 64'd1);
    @(negedge clock);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  task automatic chk_tri(input string tag, input int k,
                         input logic [31:0] x0, x1, x2, y0, y1, y2);
    chk({tag, "_x0"}, 64'(rec_x[k][0]), 64'(x0));
    chk({tag, "_x1"}, 64'(rec_x[k][1]), 64'(x1));
    chk({tag, "_x2"}, 64'(rec_x[k][2]), 64'(x2));
    chk({tag, "_y0"}, 64'(rec_y[k][0]), 64'(y0));
    chk({tag, "_y1"}, 64'(rec_y[k][1]), 64'(y1));
    chk({tag, "_y2"}, 64'(rec_y[k][2]), 64'(y2));
    chk({tag, "_z"},  64'(rec_z[k]), {16'd0, 96'({32'd1, 32'd1, 32'd1})} & 64'hffff_ffff_ffff_ffff);
  endtask

  int b_mvp, b_vtx, b_tri, b_hi, b_uns, b_se, lowc, exp_tri7;
  logic [2:0][31:0] snap_x, snap_y;
  bit found;

  initial begin
    mem[0] = {F0,  F0,  F1};
    mem[1] = {F10, F0,  F1};
    mem[2] = {F0,  F10, F1};
    mem[3] = {F0,  F0,  F1};
    mem[4] = {F0,  F10, F1};
    mem[5] = {F10, F0,  F1};
    mem[6] = {F5,  F5,  F1};
    mem[7] = '0;

    // Reset state
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_busy",      64'(busy), 64'd0);
    chk("rst_tri_valid", 64'(tri_valid), 64'd0);
    chk("rst_frame_done",64'(frame_done), 64'd0);
    chk("rst_xf_start",  64'(xf_start), 64'd0);
    chk("rst_xf_upd",    64'(xf_update_mvp), 64'd0);
    chk("rst_vmem_addr", 64'(vmem_addr), 64'd0);
    chk("rst_xf_x",      64'(xf_x), 64'd0);
    chk("rst_xf_roll",   64'(xf_roll), 64'd0);
    chk("rst_tri_x",     64'(tri_x[0]), 64'd0);

    // num_verts = 0: only the matrix rebuild
    b_mvp = n_mvp; b_vtx = n_vtx; b_tri = n_tri;
    @(negedge clock);
    num_verts = 0; frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
    chk("n0_busy",     64'(busy), 64'd1);
    chk("n0_xf_start", 64'(xf_start), 64'd1);
    chk("n0_upd_mvp",  64'(xf_update_mvp), 64'd1);
    chk("n0_xf_x",     64'(xf_x), 64'(cam_x));
    chk("n0_xf_z",     64'(xf_z), 64'(cam_z));
    chk("n0_xf_roll",  64'(xf_roll), 64'(cam_roll));
    chk("n0_xf_yaw",   64'(xf_yaw), 64'(cam_yaw));
    wait_done("n0");
    chk("n0_mvp_starts", 64'(n_mvp - b_mvp), 64'd1);
    chk("n0_vtx_starts", 64'(n_vtx - b_vtx), 64'd0);
    chk("n0_tris",       64'(n_tri - b_tri), 64'd0);

    // num_verts = 3, rasterizer always ready
    tri_ready = 1'b1;
    b_mvp = n_mvp; b_vtx = n_vtx; b_tri = n_tri;
    start_frame(3);
    wait_done("n3");
    chk("n3_tris",       64'(n_tri - b_tri), 64'd1);
    chk("n3_vtx_starts", 64'(n_vtx - b_vtx), 64'd3);
    chk("n3_mvp_starts", 64'(n_mvp - b_mvp), 64'd1);
    chk_tri("n3_t0", b_tri % 8, 320, 330, 320, 240, 240, 250);

    // num_verts = 7: two triangles (second one is reversed winding)
`ifdef TRI_BACKFACE_CULL_EN
    exp_tri7 = 1;
`else
    exp_tri7 = 2;
`endif
    b_mvp = n_mvp; b_vtx = n_vtx; b_tri = n_tri; b_hi = n_hi_addr;
    start_frame(7);
    wait_done("n7");
    chk("n7_tris",        64'(n_tri - b_tri), 64'(exp_tri7));
    chk("n7_vtx_starts",  64'(n_vtx - b_vtx), 64'd6);
    chk("n7_all_starts",  64'((n_vtx - b_vtx) + (n_mvp - b_mvp)), 64'd7);
    chk("n7_addr_ge6",    64'(n_hi_addr - b_hi), 64'd0);
    chk_tri("n7_t0", b_tri % 8, 320, 330, 320, 240, 240, 250);
    if (exp_tri7 == 2) chk_tri("n7_t1", (b_tri + 1) % 8, 320, 320, 330, 240, 250, 240);

    // Backpressure: tri_ready low for 20 EMIT cycles
    tri_ready = 1'b0;
    b_tri = n_tri; b_uns = n_unstable; b_se = n_start_in_emit; b_vtx = n_vtx;
    start_frame(3);
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clock);
      if (tri_valid) found = 1;
    end
    chk("bp_valid_rise", 64'(found), 64'd1);
    snap_x = tri_x; snap_y = tri_y;
    lowc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (!tri_valid) lowc++;
    end
    chk("bp_valid_held",   64'(lowc), 64'd0);
    chk("bp_unstable",     64'(n_unstable - b_uns), 64'd0);
    chk("bp_start_in_emit",64'(n_start_in_emit - b_se), 64'd0);
    chk("bp_vtx_starts",   64'(n_vtx - b_vtx), 64'd3);
    chk("bp_x1",           64'(snap_x[1]), 64'd330);
    chk("bp_y2",           64'(snap_y[2]), 64'd250);
    chk("bp_no_xfer_yet",  64'(n_tri - b_tri), 64'd0);
    tri_ready = 1'b1;
    @(negedge clock);
    chk("bp_valid_fall",   64'(tri_valid), 64'd0);
    chk("bp_one_xfer",     64'(n_tri - b_tri), 64'd1);
    wait_done("bp");

    // Reset while waiting on a vertex transform
    b_tri = n_tri;
    start_frame(3);
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clock);
      if (xf_start && !xf_update_mvp) found = 1;
    end
    chk("rw_vtx_issue", 64'(found), 64'd1);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rw_busy",      64'(busy), 64'd0);
    chk("rw_tri_valid", 64'(tri_valid), 64'd0);
    chk("rw_xf_start",  64'(xf_start), 64'd0);
    reset = 1'b0;
    chk("rw_no_tri",    64'(n_tri - b_tri), 64'd0);
    b_mvp = n_mvp; b_vtx = n_vtx; b_tri = n_tri;
    start_frame(3);
    wait_done("rw2");
    chk("rw2_tris",       64'(n_tri - b_tri), 64'd1);
    chk("rw2_vtx_starts", 64'(n_vtx - b_vtx), 64'd3);
    chk("rw2_mvp_starts", 64'(n_mvp - b_mvp), 64'd1);
    chk_tri("rw2_t0", b_tri % 8, 320, 330, 320, 240, 240, 250);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
